// File: rtl/wave_pkg.sv
// Shared geometry, sample width and capture state encoding
// for the scope-style waveform capture path.
package wave_pkg;

  localparam int SCREEN_WIDTH  = 1280;
  localparam int SCREEN_HEIGHT = 720;
  localparam int SAMPLE_W      = 24;

  typedef enum logic [1:0] {
    ARM,
    FILL,
    FULL
  } cap_state_t;

endpackage

// File: rtl/wave_bank_ram.sv
// Simple dual-port sample store, one write port and one
// read port with a single registered read stage.
module wave_bank_ram #(
  parameter int AW = 11,
  parameter int W  = 24
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic [AW-1:0] raddr,
  output logic [W-1:0]  rdata
);

  logic [W-1:0] mem [2**AW];

  // store an accepted sample
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // registered read of the display-side bank
  always_ff @(posedge clk) begin
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/wave_capture_buffer.sv
// Triggered, decimated audio capture into a ping-pong buffer
// that is swapped into the display path at frame start.
module wave_capture_buffer
  import wave_pkg::*;
#(
  parameter int LENGTH_OF_WAVE = 800,
  parameter int WAVE_START     = 240,
  parameter int DECIMATION     = 4,
  parameter int TRIG_TIMEOUT   = 4096
) (
  input  logic                       pixel_clk,
  input  logic                       rst_n,
  input  logic signed [SAMPLE_W-1:0] sample_in,
  input  logic                       sample_valid,
  input  logic [10:0]                h_count,
  input  logic [9:0]                 v_count,
  input  logic                       new_frame,
  output logic signed [SAMPLE_W-1:0] wave_data,
  output logic                       capture_done,
  output logic                       forced_trig
);

  localparam int AW = (LENGTH_OF_WAVE > 1) ?
    $clog2(LENGTH_OF_WAVE) : 1;
  localparam int DW = (DECIMATION > 1) ?
    $clog2(DECIMATION) : 1;
  localparam int TW = $clog2(TRIG_TIMEOUT + 1);

  localparam logic [AW-1:0] LAST_ADDR =
    AW'(LENGTH_OF_WAVE - 1);
  localparam logic [DW-1:0] DEC_LAST = DW'(DECIMATION - 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TRIG_TIMEOUT - 1);
  localparam logic [11:0]   WIN_LO   = 12'(WAVE_START);
  localparam logic [11:0]   WIN_HI   =
    12'(WAVE_START + LENGTH_OF_WAVE);

  cap_state_t state, state_nx;

  logic [DW-1:0] dec_cnt;
  logic [TW-1:0] tmo_cnt, tmo_nx;
  logic [AW-1:0] waddr, waddr_nx, wa;
  logic          forced_nx;
  logic          we, swap;
  logic          wr_bank, bank_valid;
  logic          accept, crossing;
  logic          rd_ok, rd_ok_q;
  logic [11:0]   hc;
  logic [AW-1:0] raddr;
  logic [SAMPLE_W-1:0] rdata;
  logic signed [SAMPLE_W-1:0] prev;

  assign accept   = sample_valid && (dec_cnt == '0);
  assign crossing = prev[SAMPLE_W-1] && !sample_in[SAMPLE_W-1];
  assign capture_done = (state == FULL);

  // next-state, write strobe and bank swap decode
  always_comb begin
    state_nx  = state;
    waddr_nx  = waddr;
    tmo_nx    = tmo_cnt;
    forced_nx = forced_trig;
    we        = 1'b0;
    wa        = waddr;
    swap      = 1'b0;
    unique case (state)
      ARM: begin
        if (accept) begin
          if (crossing || tmo_cnt == TMO_LAST) begin
            we        = 1'b1;
            wa        = '0;
            waddr_nx  = AW'(1);
            tmo_nx    = '0;
            forced_nx = !crossing;
            state_nx  = FILL;
          end else begin
            tmo_nx = tmo_cnt + 1'b1;
          end
        end
      end
      FILL: begin
        if (accept) begin
          we       = 1'b1;
          waddr_nx = waddr + 1'b1;
          if (waddr == LAST_ADDR) state_nx = FULL;
        end
      end
      FULL: begin
        if (new_frame) begin
          swap     = 1'b1;
          waddr_nx = '0;
          tmo_nx   = '0;
          state_nx = ARM;
        end
      end
      default: state_nx = ARM;
    endcase
  end

  // capture state and bank ownership registers
  always_ff @(posedge pixel_clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ARM;
      waddr       <= '0;
      tmo_cnt     <= '0;
      forced_trig <= 1'b0;
      wr_bank     <= 1'b0;
      bank_valid  <= 1'b0;
    end else begin
      state       <= state_nx;
      waddr       <= waddr_nx;
      tmo_cnt     <= tmo_nx;
      forced_trig <= forced_nx;
      if (swap) begin
        wr_bank    <= ~wr_bank;
        bank_valid <= 1'b1;
      end
    end
  end

  // decimation phase and zero-crossing history
  always_ff @(posedge pixel_clk or negedge rst_n) begin
    if (!rst_n) begin
      dec_cnt <= '0;
      prev    <= '0;
    end else begin
      if (sample_valid)
        dec_cnt <= (dec_cnt == DEC_LAST) ? '0 : dec_cnt + 1'b1;
      if (accept)
        prev <= sample_in;
    end
  end

  assign hc    = {1'b0, h_count};
  assign raddr = AW'(hc - WIN_LO);
  assign rd_ok = bank_valid
              && hc >= WIN_LO && hc < WIN_HI
              && h_count < 11'(SCREEN_WIDTH)
              && v_count < 10'(SCREEN_HEIGHT);

  // qualify the RAM read in step with its data
  always_ff @(posedge pixel_clk or negedge rst_n) begin
    if (!rst_n) rd_ok_q <= 1'b0;
    else        rd_ok_q <= rd_ok;
  end

  assign wave_data = rd_ok_q ? rdata : '0;

  wave_bank_ram #(
    .AW (AW + 1),
    .W  (SAMPLE_W)
  ) u_ram (
    .clk   (pixel_clk),
    .we    (we),
    .waddr ({wr_bank, wa}),
    .wdata (sample_in),
    .raddr ({~wr_bank, raddr}),
    .rdata (rdata)
  );

endmodule
